// File: rtl/calc_keypad_pkg.sv
// Shared types, field widths and keycode packing for the calculator keypad scanner.
package calc_keypad_pkg;

    localparam int unsigned KEYCODE_W = 5;
    localparam int unsigned COL_W     = 3;
    localparam int unsigned ROW_W     = 2;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed
    } scan_state_e;

    function automatic logic [KEYCODE_W-1:0] pack_keycode(input logic [COL_W-1:0] col,
                                                          input logic [ROW_W-1:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the active-low row returns; resets to all ones (no key pressed).
module keypad_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '1;
            dout   <= '1;
        end else begin
            meta_q <= din;
            dout   <= meta_q;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 5x4 key matrix scanner with debounce; one newkey pulse per accepted press.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_scanner
    import calc_keypad_pkg::*;
#(
    parameter int unsigned NCOLS       = 5,
    parameter int unsigned NROWS       = 4,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned DEB_SAMPLES = 4,
    parameter int unsigned RPT_DELAY   = 500,
    parameter int unsigned RPT_PERIOD  = 100
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NROWS-1:0]     row_n,
    output logic [NCOLS-1:0]     col_n,
    output logic                 newkey,
    output logic [KEYCODE_W-1:0] keycode,
    output logic                 key_held
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEB_SAMPLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    // deb_cnt is compared before its increment, so accept when it is one short of the target
    localparam logic [DEB_W-1:0] DEB_ACCEPT = DEB_W'(DEB_SAMPLES - 2);
    localparam logic [DEB_W-1:0] REL_LAST   = DEB_W'(DEB_SAMPLES - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NCOLS - 1);

    if (NCOLS != 5 || NROWS != 4 || SCAN_DIV < 4 || DEB_SAMPLES < 2 ||
        RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_params
        $error("keypad_scanner: unsupported parameter set");
    end

    function automatic logic [NCOLS-1:0] col_drive(input logic [COL_W-1:0] col);
        return ~(NCOLS'(1) << col);
    endfunction

    logic [NROWS-1:0] row_s;
    logic             strobe;
    logic             any_low;
    logic [ROW_W-1:0] low_row;
    logic [COL_W-1:0] col_next;

    scan_state_e      state_q;
    logic [DIV_W-1:0] div_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] cand_q;
    logic [DEB_W-1:0] deb_q;
    logic [DEB_W-1:0] rel_q;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(RPT_DELAY + RPT_PERIOD + 1);

    localparam logic [RPT_W-1:0] RPT_PRE  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_BASE = RPT_W'(RPT_DELAY);
    localparam logic [RPT_W-1:0] RPT_WRAP = RPT_W'(RPT_DELAY + RPT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q;
`endif

    keypad_sync #(
        .WIDTH (NROWS)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .din   (row_n),
        .dout  (row_s)
    );

    assign strobe   = (div_q == DIV_LAST);
    assign col_next = (col_q == COL_LAST) ? '0 : col_q + 1'b1;

    // Descending scan so the lowest-index low row is the one left standing.
    always_comb begin
        any_low = 1'b0;
        low_row = '0;
        for (int i = int'(NROWS) - 1; i >= 0; i--) begin
            if (!row_s[i]) begin
                any_low = 1'b1;
                low_row = ROW_W'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StScan;
            div_q    <= '0;
            col_q    <= '0;
            cand_q   <= '0;
            deb_q    <= '0;
            rel_q    <= '0;
            col_n    <= col_drive('0);
            newkey   <= 1'b0;
            keycode  <= '0;
            key_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q    <= '0;
`endif
        end else begin
            newkey <= 1'b0;
            div_q  <= strobe ? '0 : div_q + 1'b1;

            if (strobe) begin
                unique case (state_q)
                    StScan: begin
                        if (any_low) begin
                            cand_q  <= low_row;
                            deb_q   <= '0;
                            state_q <= StDebounce;
                        end else begin
                            col_q <= col_next;
                            col_n <= col_drive(col_next);
                        end
                    end

                    StDebounce: begin
                        if (any_low && low_row == cand_q) begin
                            deb_q <= deb_q + 1'b1;
                            if (deb_q == DEB_ACCEPT) begin
                                newkey   <= 1'b1;
                                keycode  <= pack_keycode(col_q, cand_q);
                                key_held <= 1'b1;
                                rel_q    <= '0;
                                state_q  <= StPressed;
`ifdef KEYPAD_REPEAT_EN
                                rpt_q    <= '0;
`endif
                            end
                        end else begin
                            state_q <= StScan;
                            col_q   <= col_next;
                            col_n   <= col_drive(col_next);
                        end
                    end

                    StPressed: begin
                        // Only the held key's row matters; other keys in the column are ignored.
                        if (row_s[cand_q]) begin
                            if (rel_q == REL_LAST) begin
                                key_held <= 1'b0;
                                rel_q    <= '0;
                                state_q  <= StScan;
                                col_q    <= col_next;
                                col_n    <= col_drive(col_next);
`ifdef KEYPAD_REPEAT_EN
                                rpt_q    <= '0;
`endif
                            end else begin
                                rel_q <= rel_q + 1'b1;
                            end
                        end else begin
                            rel_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rpt_q == RPT_WRAP) begin
                                newkey <= 1'b1;
                                rpt_q  <= RPT_BASE;
                            end else begin
                                if (rpt_q == RPT_PRE) begin
                                    newkey <= 1'b1;
                                end
                                rpt_q <= rpt_q + 1'b1;
                            end
`endif
                        end
                    end

                    default: state_q <= StScan;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key-matrix model driving row_n, per-cycle reference model and
// directed scenarios with literal expectations. Honours KEYPAD_REPEAT_EN like the design.
module tb_keypad_scanner;

    localparam int SCAN_DIV   = 8;
    localparam int DEB        = 3;
    localparam int RPT_DELAY  = 4;
    localparam int RPT_PERIOD = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [4:0] col_n;
    logic       newkey;
    logic [4:0] keycode;
    logic       key_held;

    logic [3:0] keys [5];

    int n_cmp   = 0;
    int n_bad   = 0;
    int nk_seen = 0;
    bit done    = 1'b0;

    // Reference model state: values the DUT outputs must hold after the latest clock edge.
    logic [4:0] exp_col_n   = 5'b11110;
    logic       exp_newkey  = 1'b0;
    logic [4:0] exp_keycode = 5'd0;
    logic       exp_held    = 1'b0;
    int cyc = 0, mode = 0, mcol = 0, cand = 0, streak = 0, quiet = 0, hs = 0;

    keypad_scanner #(
        .NCOLS       (5),
        .NROWS       (4),
        .SCAN_DIV    (SCAN_DIV),
        .DEB_SAMPLES (DEB),
        .RPT_DELAY   (RPT_DELAY),
        .RPT_PERIOD  (RPT_PERIOD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .row_n    (row_n),
        .col_n    (col_n),
        .newkey   (newkey),
        .keycode  (keycode),
        .key_held (key_held)
    );

    initial forever #5 clock = ~clock;

    // Passive matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c][r] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic advance();
        mcol      = (mcol + 1) % 5;
        exp_col_n = 5'b11111;
        exp_col_n[mcol] = 1'b0;
    endtask

    // One sample point of the key-matrix rules, using the bench's own column and key table.
    task automatic model_strobe();
        int low = -1;
        for (int r = 3; r >= 0; r--) begin
            if (keys[mcol][r]) low = r;
        end
        case (mode)
            0: begin
                if (low < 0) advance();
                else begin
                    cand   = low;
                    streak = 1;
                    mode   = 1;
                end
            end
            1: begin
                if (low == cand) begin
                    streak++;
                    if (streak == DEB) begin
                        exp_newkey  = 1'b1;
                        exp_keycode = 5'(mcol * 4 + cand);
                        exp_held    = 1'b1;
                        mode        = 2;
                        quiet       = 0;
                        hs          = 0;
                    end
                end else begin
                    mode = 0;
                    advance();
                end
            end
            default: begin
                if (!keys[mcol][cand]) begin
                    quiet++;
                    if (quiet == DEB) begin
                        exp_held = 1'b0;
                        mode     = 0;
                        advance();
                    end
                end else begin
                    quiet = 0;
                    hs++;
`ifdef KEYPAD_REPEAT_EN
                    if (hs == RPT_DELAY || (hs > RPT_DELAY && (hs - RPT_DELAY) % RPT_PERIOD == 0))
                        exp_newkey = 1'b1;
`endif
                end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                cyc = 0; mode = 0; mcol = 0; cand = 0; streak = 0; quiet = 0; hs = 0;
                exp_col_n = 5'b11110; exp_newkey = 1'b0; exp_keycode = 5'd0; exp_held = 1'b0;
            end else begin
                cyc++;
                exp_newkey = 1'b0;
                if (cyc % SCAN_DIV == 0) model_strobe();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        bit prev_nk = 1'b0;
        forever begin
            @(negedge clock);
            if (done) break;
            chk("col_n", int'(col_n), int'(exp_col_n));
            chk("newkey", int'(newkey), int'(exp_newkey));
            chk("keycode", int'(keycode), int'(exp_keycode));
            chk("key_held", int'(key_held), int'(exp_held));
            chk("newkey_back_to_back", int'(newkey && prev_nk), 0);
            if (newkey) nk_seen++;
            prev_nk = newkey;
        end
    end

    task automatic step(input int n);
        repeat (n * SCAN_DIV) @(negedge clock);
        #2;
    endtask

    initial begin
        int base;
        logic [4:0] seq [6];
        seq[0] = 5'b11110; seq[1] = 5'b11101; seq[2] = 5'b11011;
        seq[3] = 5'b10111; seq[4] = 5'b01111; seq[5] = 5'b11110;
        for (int c = 0; c < 5; c++) keys[c] = 4'h0;

        repeat (3) @(negedge clock);
        #2;
        chk("rst_col_n", int'(col_n), 'b11110);
        chk("rst_newkey", int'(newkey), 0);
        chk("rst_keycode", int'(keycode), 0);
        chk("rst_key_held", int'(key_held), 0);
        reset = 1'b0;

        // Idle scan walks every column and wraps.
        for (int i = 0; i < 6; i++) begin
            chk("idle_scan_col", int'(col_n), int'(seq[i]));
            if (i < 5) step(1);
        end
        chk("idle_no_newkey", nk_seen, 0);

        // Clean press of col 2 / row 1.
        base = nk_seen;
        keys[2][1] = 1'b1;
        step(6);
        chk("press_count", nk_seen - base, 1);
        chk("press_keycode", int'(keycode), 'b01001);
        chk("press_held", int'(key_held), 1);
        keys[2][1] = 1'b0;
        step(2);
        chk("release_partial_held", int'(key_held), 1);
        step(1);
        chk("release_held", int'(key_held), 0);
        chk("release_resume_col3", int'(col_n), 'b10111);

        // Col 4 / row 3 bounces, then settles.
        base = nk_seen;
        keys[4][3] = 1'b1;
        step(2);
        keys[4][3] = 1'b0;
        step(1);
        chk("bounce_no_newkey", nk_seen - base, 0);
        chk("bounce_abandon_col0", int'(col_n), 'b11110);
        keys[4][3] = 1'b1;
        step(8);
        chk("bounce_count", nk_seen - base, 1);
        chk("bounce_keycode", int'(keycode), 'b10011);
        chk("bounce_held", int'(key_held), 1);
        keys[4][3] = 1'b0;
        step(3);
        chk("bounce_release_held", int'(key_held), 0);

        // Single-sample glitch on col 0 / row 0.
        base = nk_seen;
        keys[0][0] = 1'b1;
        step(1);
        keys[0][0] = 1'b0;
        step(1);
        chk("glitch_no_newkey", nk_seen - base, 0);
        chk("glitch_col1", int'(col_n), 'b11101);
        chk("glitch_held", int'(key_held), 0);

        // Two rows in col 1: lowest row wins; then reset while pressed.
        base = nk_seen;
        keys[1][1] = 1'b1;
        keys[1][2] = 1'b1;
        step(3);
        chk("dual_count", nk_seen - base, 1);
        chk("dual_keycode", int'(keycode), 'b00101);
        chk("dual_held", int'(key_held), 1);
        reset = 1'b1;
        keys[1][1] = 1'b0;
        keys[1][2] = 1'b0;
        base = nk_seen;
        @(negedge clock);
        #2;
        chk("midrst_col_n", int'(col_n), 'b11110);
        chk("midrst_newkey", int'(newkey), 0);
        chk("midrst_keycode", int'(keycode), 0);
        chk("midrst_held", int'(key_held), 0);
        chk("midrst_no_pulse", nk_seen - base, 0);

        // Hold col 3 / row 0 for 12 strobes past acceptance.
        keys[3][0] = 1'b1;
        reset = 1'b0;
        base = nk_seen;
        step(18);
`ifdef KEYPAD_REPEAT_EN
        chk("hold_count", nk_seen - base, 6);
`else
        chk("hold_count", nk_seen - base, 1);
`endif
        chk("hold_keycode", int'(keycode), 'b01100);
        chk("hold_held", int'(key_held), 1);
        keys[3][0] = 1'b0;
        step(3);
        chk("hold_release_held", int'(key_held), 0);
        chk("hold_release_col4", int'(col_n), 'b01111);

        done = 1'b1;
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
